sprite_compositor: RTL and testbench

//  Pixel-stage renderer directly downstream of the VGA timing driver. Consumes xPixel/yPixel/VGAblanck/hsync/vsync
//  and produces 8-bit RGB from a table of NUM_SPRITES solid-colour rectangles over a background colour.

---
 rtl/sprite_compositor_pkg.sv | 22 ++
 rtl/sprite_compositor_if.sv | 38 +++
 rtl/sprite_hit.sv | 25 ++
 rtl/sprite_compositor.sv | 122 ++++++++++++
 tb/tb_sprite_compositor.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_compositor_pkg.sv
// Shared geometry, colour widths and the sprite table entry type for the
// sprite compositor and its rectangle comparator.
package sprite_compositor_pkg;

    localparam int SPRITE_X_W = 10;
    localparam int SPRITE_Y_W = 9;
    localparam int COLOR_W    = 24;
    localparam int H_VISIBLE  = 640;
    localparam int V_VISIBLE  = 480;

    localparam logic [COLOR_W-1:0] BG_COLOR_DEFAULT = 24'h000040;

    typedef struct packed {
        logic                  visible;
        logic [SPRITE_X_W-1:0] x;
        logic [SPRITE_Y_W-1:0] y;
        logic [SPRITE_X_W-1:0] w;
        logic [SPRITE_Y_W-1:0] h;
        logic [COLOR_W-1:0]    color;
    } sprite_t;

endpackage

// File: rtl/sprite_compositor_if.sv
// Pixel stream from the timing driver, shadow-table write port from game
// logic, and the aligned RGB/sync outputs of the compositor.
interface sprite_compositor_if #(
    parameter int IDX_W = 3
);
    logic [9:0]       xPixel;
    logic [8:0]       yPixel;
    logic             VGAblanck;
    logic             hsyncIn;
    logic             vsyncIn;
    logic             wrEn;
    logic [IDX_W-1:0] wrIndex;
    logic [9:0]       wrX;
    logic [8:0]       wrY;
    logic [9:0]       wrW;
    logic [8:0]       wrH;
    logic [23:0]      wrColor;
    logic             wrVisible;
    logic [7:0]       red;
    logic [7:0]       green;
    logic [7:0]       blue;
    logic             hsyncOut;
    logic             vsyncOut;
    logic             blankOut;
    logic [15:0]      frameCount;

    modport master (
        output xPixel, yPixel, VGAblanck, hsyncIn, vsyncIn,
        output wrEn, wrIndex, wrX, wrY, wrW, wrH, wrColor, wrVisible,
        input  red, green, blue, hsyncOut, vsyncOut, blankOut, frameCount
    );

    modport slave (
        input  xPixel, yPixel, VGAblanck, hsyncIn, vsyncIn,
        input  wrEn, wrIndex, wrX, wrY, wrW, wrH, wrColor, wrVisible,
        output red, green, blue, hsyncOut, vsyncOut, blankOut, frameCount
    );
endinterface

// File: rtl/sprite_hit.sv
// Single-rectangle hit test. End coordinates are formed one bit wider so a
// rectangle running past the screen edge clips instead of wrapping to 0.
module sprite_hit
    import sprite_compositor_pkg::*;
(
    input  logic [SPRITE_X_W-1:0] x,
    input  logic [SPRITE_Y_W-1:0] y,
    input  logic [SPRITE_X_W-1:0] sx,
    input  logic [SPRITE_Y_W-1:0] sy,
    input  logic [SPRITE_X_W-1:0] w,
    input  logic [SPRITE_Y_W-1:0] h,
    input  logic                  visible,
    output logic                  hit
);
    logic [SPRITE_X_W:0] x_end;
    logic [SPRITE_Y_W:0] y_end;

    always_comb begin
        x_end = {1'b0, sx} + {1'b0, w};
        y_end = {1'b0, sy} + {1'b0, h};
        hit   = visible
              & (x >= sx) & ({1'b0, x} < x_end) & (x < SPRITE_X_W'(H_VISIBLE))
              & (y >= sy) & ({1'b0, y} < y_end) & (y < SPRITE_Y_W'(V_VISIBLE));
    end
endmodule

// File: rtl/sprite_compositor.sv
// Two-stage sprite renderer: hit test against the live table, then priority
// colour select. Shadow table is copied to live on each vsync falling edge.
module sprite_compositor
    import sprite_compositor_pkg::*;
#(
    parameter int                 NUM_SPRITES = 8,
    parameter int                 IDX_W       = 3,
    parameter logic [COLOR_W-1:0] BG_COLOR    = BG_COLOR_DEFAULT
) (
    input logic                VGAclock,
    input logic                resetN,
    sprite_compositor_if.slave bus
);
    sprite_t shadow_q [NUM_SPRITES];
    sprite_t shadow_d [NUM_SPRITES];
    sprite_t live_q   [NUM_SPRITES];
    sprite_t live_d   [NUM_SPRITES];
    sprite_t wr_entry;

    logic [IDX_W-1:0]       wr_idx;
    logic                   vs_prev_q, vs_prev_d;
    logic                   commit;
    logic [15:0]            frame_q, frame_d;
    logic [NUM_SPRITES-1:0] hit_p0;
    logic [NUM_SPRITES-1:0] hit_p1_q, hit_p1_d;
    logic                   blank_p1_q, blank_p1_d, hs_p1_q, hs_p1_d, vs_p1_q, vs_p1_d;
    logic                   blank_p2_q, blank_p2_d, hs_p2_q, hs_p2_d, vs_p2_q, vs_p2_d;
    logic [COLOR_W-1:0]     rgb_p2_q, rgb_p2_d;

    assign wr_idx = bus.wrIndex;
    assign commit = vs_prev_q & ~bus.vsyncIn;

    always_comb begin
        wr_entry = '{visible: bus.wrVisible, x: bus.wrX, y: bus.wrY,
                     w: bus.wrW, h: bus.wrH, color: bus.wrColor};
        shadow_d  = shadow_q;
        live_d    = live_q;
        frame_d   = frame_q;
        vs_prev_d = bus.vsyncIn;
        // live captures the pre-write shadow when a write lands on the commit cycle
        if (commit) begin
            live_d  = shadow_q;
            frame_d = frame_q + 16'd1;
        end
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (bus.wrEn && wr_idx == IDX_W'(i)) shadow_d[i] = wr_entry;
        end
    end

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
        sprite_hit u_hit (
            .x       (bus.xPixel),
            .y       (bus.yPixel),
            .sx      (live_q[g].x),
            .sy      (live_q[g].y),
            .w       (live_q[g].w),
            .h       (live_q[g].h),
            .visible (live_q[g].visible),
            .hit     (hit_p0[g])
        );
    end

    // stage 1: hit vector and delayed timing
    always_comb begin
        hit_p1_d   = hit_p0;
        blank_p1_d = bus.VGAblanck;
        hs_p1_d    = bus.hsyncIn;
        vs_p1_d    = bus.vsyncIn;
    end

    // stage 2: lowest-index hit wins, blanking forces black
    always_comb begin
        blank_p2_d = blank_p1_q;
        hs_p2_d    = hs_p1_q;
        vs_p2_d    = vs_p1_q;
        rgb_p2_d   = BG_COLOR;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit_p1_q[i]) rgb_p2_d = live_q[i].color;
        end
        if (!blank_p1_q) rgb_p2_d = '0;
    end

    always_ff @(posedge VGAclock) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                shadow_q[i] <= '0;
                live_q[i]   <= '0;
            end
            vs_prev_q  <= 1'b0;
            frame_q    <= '0;
            hit_p1_q   <= '0;
            blank_p1_q <= 1'b0;
            hs_p1_q    <= 1'b1;
            vs_p1_q    <= 1'b1;
            blank_p2_q <= 1'b0;
            hs_p2_q    <= 1'b1;
            vs_p2_q    <= 1'b1;
            rgb_p2_q   <= '0;
        end else begin
            shadow_q   <= shadow_d;
            live_q     <= live_d;
            vs_prev_q  <= vs_prev_d;
            frame_q    <= frame_d;
            hit_p1_q   <= hit_p1_d;
            blank_p1_q <= blank_p1_d;
            hs_p1_q    <= hs_p1_d;
            vs_p1_q    <= vs_p1_d;
            blank_p2_q <= blank_p2_d;
            hs_p2_q    <= hs_p2_d;
            vs_p2_q    <= vs_p2_d;
            rgb_p2_q   <= rgb_p2_d;
        end
    end

    assign bus.red        = rgb_p2_q[23:16];
    assign bus.green      = rgb_p2_q[15:8];
    assign bus.blue       = rgb_p2_q[7:0];
    assign bus.hsyncOut   = hs_p2_q;
    assign bus.vsyncOut   = vs_p2_q;
    assign bus.blankOut   = blank_p2_q;
    assign bus.frameCount = frame_q;
endmodule

// File: tb/tb_sprite_compositor.sv
// Scoreboard bench for sprite_compositor: a behavioural table model predicts
// every output pixel two cycles ahead; directed pixels also carry fixed colours.
module tb_sprite_compositor;
    import sprite_compositor_pkg::*;

    // six sprites so that index 6 is representable and must be ignored
    localparam int          NUM = 6;
    localparam logic [23:0] BG  = 24'h000040;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sprite_compositor_if #(.IDX_W(3)) bus ();

    sprite_compositor #(.NUM_SPRITES(NUM), .IDX_W(3), .BG_COLOR(BG)) dut (
        .VGAclock (clk),
        .resetN   (rst_n),
        .bus      (bus)
    );

    typedef struct {
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        blank;
        bit          has_want;
        logic [23:0] want;
    } exp_t;

    exp_t    sb[$];
    int      tests = 0;
    int      fails = 0;
    sprite_t m_shadow [NUM];
    sprite_t m_live   [NUM];
    logic    m_prev = 1'b0;
    int      m_fc = 0;
    int      pulses = 0;
    bit      rst_prev = 1'b0;

    int      d_x = 0, d_y = 0, d_idx = 0;
    logic    d_blank = 0, d_hs = 1, d_vs = 1, d_rstn = 0, d_wr = 0;
    sprite_t d_spr = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [23:0] model_color(input int x, input int y);
        for (int i = 0; i < NUM; i++) begin
            if (m_live[i].visible &&
                x >= int'(m_live[i].x) && x < int'(m_live[i].x) + int'(m_live[i].w) &&
                y >= int'(m_live[i].y) && y < int'(m_live[i].y) + int'(m_live[i].h) &&
                x < 640 && y < 480)
                return m_live[i].color;
        end
        return BG;
    endfunction

    task automatic cycle(input bit has_want = 1'b0, input logic [23:0] want = 24'h0);
        exp_t e;
        @(negedge clk);
        if (rst_prev) begin
            check("rst_rgb",   {8'h0, bus.red, bus.green, bus.blue}, 32'h0);
            check("rst_hsync", {31'h0, bus.hsyncOut}, 32'h1);
            check("rst_vsync", {31'h0, bus.vsyncOut}, 32'h1);
            check("rst_blank", {31'h0, bus.blankOut}, 32'h0);
        end
        if (sb.size() == 2) begin
            e = sb.pop_front();
            check("rgb",   {8'h0, bus.red, bus.green, bus.blue}, {8'h0, e.rgb});
            check("hsync", {31'h0, bus.hsyncOut}, {31'h0, e.hs});
            check("vsync", {31'h0, bus.vsyncOut}, {31'h0, e.vs});
            check("blank", {31'h0, bus.blankOut}, {31'h0, e.blank});
            if (e.has_want) check("pixel", {8'h0, bus.red, bus.green, bus.blue}, {8'h0, e.want});
        end
        check("frameCount", {16'h0, bus.frameCount}, 32'(m_fc & 16'hFFFF));

        rst_n         = d_rstn;
        bus.xPixel    = 10'(d_x);
        bus.yPixel    = 9'(d_y);
        bus.VGAblanck = d_blank;
        bus.hsyncIn   = d_hs;
        bus.vsyncIn   = d_vs;
        bus.wrEn      = d_wr;
        bus.wrIndex   = 3'(d_idx);
        bus.wrX       = d_spr.x;
        bus.wrY       = d_spr.y;
        bus.wrW       = d_spr.w;
        bus.wrH       = d_spr.h;
        bus.wrColor   = d_spr.color;
        bus.wrVisible = d_spr.visible;

        e.has_want = has_want;
        e.want     = want;
        if (!d_rstn) begin
            e.rgb = 24'h0; e.hs = 1'b1; e.vs = 1'b1; e.blank = 1'b0;
            for (int i = 0; i < NUM; i++) begin
                m_shadow[i] = '0;
                m_live[i]   = '0;
            end
            m_prev = 1'b0;
            m_fc   = 0;
        end else begin
            e.rgb = d_blank ? model_color(d_x, d_y) : 24'h0;
            e.hs = d_hs; e.vs = d_vs; e.blank = d_blank;
            if (m_prev && !d_vs) begin
                for (int i = 0; i < NUM; i++) m_live[i] = m_shadow[i];
                m_fc++;
            end
            if (d_wr && d_idx < NUM) m_shadow[d_idx] = d_spr;
            m_prev = d_vs;
        end
        sb.push_back(e);
        rst_prev = !d_rstn;
    endtask

    task automatic set_wr(input int idx, input int x, input int y, input int w, input int h,
                          input logic [23:0] col, input logic vis);
        d_wr  = 1'b1;
        d_idx = idx;
        d_spr = '{visible: vis, x: 10'(x), y: 9'(y), w: 10'(w), h: 9'(h), color: col};
    endtask

    task automatic write(input int idx, input int x, input int y, input int w, input int h,
                         input logic [23:0] col, input logic vis);
        d_blank = 1'b0;
        set_wr(idx, x, y, w, h, col, vis);
        cycle();
        d_wr = 1'b0;
    endtask

    task automatic vpulse();
        d_blank = 1'b0;
        d_vs = 1'b0; cycle(); cycle();
        d_vs = 1'b1; cycle();
        pulses++;
        check("fc_pulses", {16'h0, bus.frameCount}, 32'(pulses));
    endtask

    task automatic pix(input int x, input int y, input logic [23:0] want, input logic blank = 1'b1);
        d_x = x; d_y = y; d_blank = blank;
        cycle(1'b1, want);
        d_blank = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.xPixel = '0; bus.yPixel = '0; bus.VGAblanck = 1'b0;
        bus.hsyncIn = 1'b1; bus.vsyncIn = 1'b1; bus.wrEn = 1'b0; bus.wrIndex = '0;
        bus.wrX = '0; bus.wrY = '0; bus.wrW = '0; bus.wrH = '0;
        bus.wrColor = '0; bus.wrVisible = 1'b0;

        // reset with random activity on every input
        repeat (3) begin
            d_rstn = 1'b0;
            d_x = $urandom_range(0, 639); d_y = $urandom_range(0, 479);
            d_blank = 1'($urandom); d_hs = 1'($urandom); d_vs = 1'($urandom);
            set_wr($urandom_range(0, 7), $urandom_range(0, 639), $urandom_range(0, 479),
                   $urandom_range(0, 639), $urandom_range(0, 479), 24'($urandom), 1'b1);
            cycle();
        end
        d_rstn = 1'b1; d_wr = 1'b0; d_blank = 1'b0; d_hs = 1'b1; d_vs = 1'b1;
        repeat (2) cycle();

        // single sprite, invisible until committed
        write(0, 100, 50, 20, 10, 24'hFF0000, 1'b1);
        pix(100, 50, BG);
        vpulse();
        pix(100, 50, 24'hFF0000);
        pix(119, 59, 24'hFF0000);
        pix(120, 50, BG);
        pix(100, 60, BG);

        // priority and overlap
        write(2, 0, 0, 640, 480, 24'h00FF00, 1'b1);
        write(1, 10, 10, 5, 5, 24'h0000FF, 1'b1);
        vpulse();
        pix(12, 12, 24'h0000FF);
        pix(0, 0, 24'h00FF00);
        pix(105, 55, 24'hFF0000);
        write(2, 0, 0, 640, 480, 24'h00FF00, 1'b0);
        vpulse();
        pix(0, 0, BG);
        pix(12, 12, 24'h0000FF);

        // tear-free update and write on the commit cycle
        write(0, 100, 50, 20, 10, 24'h123456, 1'b1);
        pix(100, 50, 24'hFF0000);
        vpulse();
        pix(100, 50, 24'h123456);
        d_blank = 1'b0; d_vs = 1'b0;
        set_wr(0, 100, 50, 20, 10, 24'hABCDEF, 1'b1);
        cycle();
        d_wr = 1'b0; cycle();
        d_vs = 1'b1; cycle();
        pulses++;
        check("fc_commit_wr", {16'h0, bus.frameCount}, 32'(pulses));
        pix(100, 50, 24'h123456);
        vpulse();
        pix(100, 50, 24'hABCDEF);

        // right-edge clipping, out-of-range index, blanking over a hit
        write(3, 630, 200, 20, 5, 24'hC0FFEE, 1'b1);
        write(6, 0, 0, 640, 480, 24'hFFFFFF, 1'b1);
        vpulse();
        pix(630, 200, 24'hC0FFEE);
        pix(639, 204, 24'hC0FFEE);
        pix(629, 200, BG);
        pix(0, 200, BG);
        pix(0, 300, BG);
        pix(100, 50, 24'h000000, 1'b0);
        pix(12, 12, 24'h000000, 1'b0);

        // random sync/blank stream; blanking always covers vsync
        for (int n = 0; n < 200; n++) begin
            d_x = $urandom_range(0, 639); d_y = $urandom_range(0, 479);
            d_hs = 1'($urandom);
            d_vs = ($urandom_range(0, 9) == 0) ? 1'b0 : 1'b1;
            d_blank = d_vs ? 1'($urandom) : 1'b0;
            cycle();
        end
        d_vs = 1'b1; d_hs = 1'b1; d_blank = 1'b0;
        repeat (2) cycle();

        // reset mid-frame on a lit pixel, then the table must be empty
        d_x = 105; d_y = 55; d_blank = 1'b1; d_rstn = 1'b0;
        cycle();
        d_rstn = 1'b1;
        pix(105, 55, BG);
        pix(12, 12, BG);
        d_blank = 1'b0; d_vs = 1'b1; cycle();
        d_vs = 1'b0; cycle(); cycle();
        d_vs = 1'b1; cycle();
        check("fc_after_rst", {16'h0, bus.frameCount}, 32'h1);
        pix(105, 55, BG);
        repeat (3) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
